mips_multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the MIPS core. It drives instruction fetch, loads the IR that feeds the Decoder, and steps each instruction through DECODE/EXEC/MEM/WB. It emits per-cycle datapath enables and muxes from the Decoder's op/funct fields. It handshakes with instruction and data memory, and traps on illegal opcodes or memory timeouts.

---
 rtl/mips_pkg.sv | 86 ++++++++
 rtl/mips_instr_class.sv | 38 +++
 rtl/mips_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and enumerations for the multi-cycle MIPS control path.
package mips_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0c;
    localparam logic [5:0] FN_BREAK   = 6'h0d;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_AND     = 6'h24;

    // Register file destination select
    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_REG    = 2'd3
    } pc_src_t;

    typedef enum logic [1:0] {
        SRCB_RT   = 2'd0,
        SRCB_SIMM = 2'd1,
        SRCB_ZIMM = 2'd2,
        SRCB_LUI  = 2'd3
    } alu_src_b_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_AND   = 3'd1,
        ALU_OR    = 3'd2,
        ALU_PASSB = 3'd3,
        ALU_SUB   = 3'd4
    } alu_op_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_BREAK   = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } trap_cause_t;

    // Instruction classes: each class has one fixed path through the FSM
    typedef enum logic [3:0] {
        CL_ILLEGAL,
        CL_R_ADD,
        CL_R_AND,
        CL_JR,
        CL_SYSCALL,
        CL_BREAK,
        CL_ADDI,
        CL_ORI,
        CL_LUI,
        CL_LW,
        CL_SW,
        CL_BGTZ,
        CL_J,
        CL_JAL
    } instr_class_t;

endpackage

// File: rtl/mips_instr_class.sv
// Combinational classifier: maps op/funct to an instruction class and legality.
module mips_instr_class
    import mips_pkg::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   funct,
    output instr_class_t iclass,
    output logic         legal
);

    // Anything not explicitly recognised (including COP1) falls to CL_ILLEGAL
    always_comb begin
        iclass = CL_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: iclass = CL_R_ADD;
                    FN_AND:          iclass = CL_R_AND;
                    FN_JR:           iclass = CL_JR;
                    FN_SYSCALL:      iclass = CL_SYSCALL;
                    FN_BREAK:        iclass = CL_BREAK;
                    default:         iclass = CL_ILLEGAL;
                endcase
            end
            OP_J:              iclass = CL_J;
            OP_JAL:            iclass = CL_JAL;
            OP_BGTZ:           iclass = CL_BGTZ;
            OP_ADDI, OP_ADDIU: iclass = CL_ADDI;
            OP_ORI:            iclass = CL_ORI;
            OP_LUI:            iclass = CL_LUI;
            OP_LW:             iclass = CL_LW;
            OP_SW:             iclass = CL_SW;
            default:           iclass = CL_ILLEGAL;
        endcase
        legal = (iclass != CL_ILLEGAL);
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, a shared wait counter for bus timeouts, and a sticky trap state.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       br_taken,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic       mem_to_reg,
    output logic       syscall,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_cause
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    trap_cause_t      cause_q, cause_d;
    instr_class_t     iclass;
    logic             legal;
    logic             timeout_hit;

    mips_instr_class u_instr_class (
        .op     (op),
        .funct  (funct),
        .iclass (iclass),
        .legal  (legal)
    );

    // The current cycle is the last allowed wait cycle for a pending request
    assign timeout_hit = (wait_q == CNT_W'(MEM_TIMEOUT - 1));

    // Next state, wait counter and trap cause; an ack always beats a timeout
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DECODE: begin
                if (!legal) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (iclass == CL_J || iclass == CL_JAL) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (iclass)
                    CL_LW, CL_SW:                state_d = ST_MEM;
                    CL_BGTZ, CL_JR, CL_SYSCALL:  state_d = ST_FETCH;
                    CL_BREAK: begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_BREAK;
                    end
                    default:                     state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = (iclass == CL_SW) ? ST_FETCH : ST_WB;
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, wait counter and trap cause registers; reset returns to IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    // Datapath controls decoded from state and class; fetch/mem acks act Mealy-style
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_PLUS4;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        reg_dst    = REG_DST_RT;
        mem_to_reg = 1'b0;
        syscall    = 1'b0;
        retire     = 1'b0;
        trap       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_src = PC_PLUS4;
                end
            end
            ST_DECODE: begin
                if (iclass == CL_J || iclass == CL_JAL) begin
                    pc_we  = 1'b1;
                    pc_src = PC_JUMP;
                    retire = 1'b1;
                    if (iclass == CL_JAL) begin
                        reg_write = 1'b1;
                        reg_dst   = REG_DST_RA;
                    end
                end
            end
            ST_EXEC: begin
                case (iclass)
                    CL_R_ADD: begin
                        alu_src_b = SRCB_RT;
                        alu_op    = ALU_ADD;
                    end
                    CL_R_AND: begin
                        alu_src_b = SRCB_RT;
                        alu_op    = ALU_AND;
                    end
                    CL_ADDI, CL_LW, CL_SW: begin
                        alu_src_b = SRCB_SIMM;
                        alu_op    = ALU_ADD;
                    end
                    CL_ORI: begin
                        alu_src_b = SRCB_ZIMM;
                        alu_op    = ALU_OR;
                    end
                    CL_LUI: begin
                        alu_src_b = SRCB_LUI;
                        alu_op    = ALU_PASSB;
                    end
                    CL_BGTZ: begin
                        pc_src = PC_BRANCH;
                        pc_we  = br_taken;
                        retire = 1'b1;
                    end
                    CL_JR: begin
                        pc_src = PC_REG;
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                    CL_SYSCALL: begin
                        syscall = 1'b1;
                        retire  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (iclass == CL_SW);
                retire   = dmem_ack && (iclass == CL_SW);
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (iclass == CL_R_ADD || iclass == CL_R_AND) ? REG_DST_RD : REG_DST_RT;
                mem_to_reg = (iclass == CL_LW);
                retire     = 1'b1;
            end
            ST_TRAP: trap = 1'b1;
            default: ;
        endcase
        trap_cause = cause_q;
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: random instruction/ack-delay sequences compared cycle by
// cycle against a per-instruction trace model built from the ISA timing rules.
module tb_mips_multicycle_ctrl;

    localparam int TO = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       br_taken;
    logic       imem_ack;
    logic       dmem_ack;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       syscall;
    logic       retire;
    logic       trap;
    logic [1:0] trap_cause;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        logic       syscall;
        logic       retire;
        logic       trap;
        logic [1:0] trap_cause;
    } outs_t;

    typedef struct packed {
        outs_t v;
        logic  ia;
        logic  da;
        logic  ld;
    } step_t;

    step_t exp_q[$];
    outs_t obs_q[$];
    outs_t obs;
    int    tests_run    = 0;
    int    tests_failed = 0;

    always #5 clk = ~clk;

    assign obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_src_b, alu_op,
                  reg_write, reg_dst, mem_to_reg, syscall, retire, trap, trap_cause};

    mips_multicycle_ctrl #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .br_taken   (br_taken),
        .imem_ack   (imem_ack),
        .dmem_ack   (dmem_ack),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .syscall    (syscall),
        .retire     (retire),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    // ---------------- reference model ----------------

    function automatic bit is_legal(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00)
            return (f == 6'h20 || f == 6'h21 || f == 6'h24 || f == 6'h08 || f == 6'h0c || f == 6'h0d);
        return (o == 6'h02 || o == 6'h03 || o == 6'h07 || o == 6'h08 || o == 6'h09 ||
                o == 6'h0d || o == 6'h0f || o == 6'h23 || o == 6'h2b);
    endfunction

    function automatic outs_t fetch_vec(input bit ack);
        outs_t v = '0;
        v.imem_req = 1'b1;
        if (ack) begin
            v.ir_we = 1'b1;
            v.pc_we = 1'b1;
        end
        return v;
    endfunction

    function automatic outs_t mem_vec(input bit is_sw, input bit ack);
        outs_t v = '0;
        v.dmem_req = 1'b1;
        v.dmem_we  = is_sw;
        v.retire   = is_sw && ack;
        return v;
    endfunction

    function automatic outs_t trap_vec(input logic [1:0] c);
        outs_t v = '0;
        v.trap       = 1'b1;
        v.trap_cause = c;
        return v;
    endfunction

    function automatic void add_step(input outs_t v, input bit ia, input bit da, input bit ld);
        step_t s;
        s.v  = v;
        s.ia = ia;
        s.da = da;
        s.ld = ld;
        exp_q.push_back(s);
    endfunction

    // Builds the expected per-cycle trace from a fresh FETCH; returns 1 if it ends in TRAP
    function automatic bit build_trace(input logic [31:0] w, input int idly, input int ddly, input bit br);
        logic [5:0] o;
        logic [5:0] f;
        logic [1:0] cause;
        outs_t      v;
        bit         wb;
        bit         mem;
        bit         is_sw;
        o     = w[31:26];
        f     = w[5:0];
        cause = 2'd0;
        wb    = 1'b0;
        mem   = 1'b0;
        is_sw = (o == 6'h2b);
        exp_q.delete();
        if (idly >= TO) begin
            for (int i = 0; i < TO; i++) add_step(fetch_vec(1'b0), 1'b0, 1'b0, 1'b0);
            cause = 2'd3;
        end else begin
            for (int i = 0; i < idly; i++) add_step(fetch_vec(1'b0), 1'b0, 1'b0, 1'b0);
            add_step(fetch_vec(1'b1), 1'b1, 1'b0, 1'b0);
            v = '0;
            if (o == 6'h02 || o == 6'h03) begin
                v.pc_we  = 1'b1;
                v.pc_src = 2'd2;
                v.retire = 1'b1;
                if (o == 6'h03) begin
                    v.reg_write = 1'b1;
                    v.reg_dst   = 2'd2;
                end
                add_step(v, 1'b0, 1'b0, 1'b1);
                return 1'b0;
            end
            add_step(v, 1'b0, 1'b0, 1'b1);
            if (!is_legal(o, f)) begin
                cause = 2'd1;
            end else begin
                v = '0;
                if (o == 6'h00) begin
                    case (f)
                        6'h20, 6'h21: wb = 1'b1;
                        6'h24: begin v.alu_op = 3'd1; wb = 1'b1; end
                        6'h08: begin v.pc_we = 1'b1; v.pc_src = 2'd3; v.retire = 1'b1; end
                        6'h0c: begin v.syscall = 1'b1; v.retire = 1'b1; end
                        default: cause = 2'd2;
                    endcase
                end else begin
                    case (o)
                        6'h08, 6'h09: begin v.alu_src_b = 2'd1; wb = 1'b1; end
                        6'h0d: begin v.alu_src_b = 2'd2; v.alu_op = 3'd2; wb = 1'b1; end
                        6'h0f: begin v.alu_src_b = 2'd3; v.alu_op = 3'd3; wb = 1'b1; end
                        6'h07: begin v.pc_src = 2'd1; v.pc_we = br; v.retire = 1'b1; end
                        default: begin v.alu_src_b = 2'd1; mem = 1'b1; end
                    endcase
                end
                add_step(v, 1'b0, 1'b0, 1'b0);
                if (mem) begin
                    if (ddly >= TO) begin
                        for (int i = 0; i < TO; i++) add_step(mem_vec(is_sw, 1'b0), 1'b0, 1'b0, 1'b0);
                        cause = 2'd3;
                    end else begin
                        for (int i = 0; i < ddly; i++) add_step(mem_vec(is_sw, 1'b0), 1'b0, 1'b0, 1'b0);
                        add_step(mem_vec(is_sw, 1'b1), 1'b0, 1'b1, 1'b0);
                        wb = !is_sw;
                    end
                end
                if (wb) begin
                    v = '0;
                    v.reg_write  = 1'b1;
                    v.reg_dst    = (o == 6'h00) ? 2'd1 : 2'd0;
                    v.mem_to_reg = (o == 6'h23);
                    v.retire     = 1'b1;
                    add_step(v, 1'b0, 1'b0, 1'b0);
                end
            end
        end
        if (cause != 2'd0) begin
            for (int i = 0; i < 3; i++) add_step(trap_vec(cause), 1'b1, 1'b1, 1'b0);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // ---------------- drivers ----------------

    // Runs one instruction from a fresh FETCH, recording outputs at each negedge
    task automatic exec_instr(input logic [31:0] w, input int idly, input int ddly,
                              input bit br, output bit trapped);
        trapped = build_trace(w, idly, ddly, br);
        obs_q.delete();
        foreach (exp_q[i]) begin
            imem_ack = exp_q[i].ia;
            dmem_ack = exp_q[i].da;
            br_taken = br;
            if (exp_q[i].ld) begin
                op    = w[31:26];
                funct = w[5:0];
            end
            @(negedge clk);
            obs_q.push_back(obs);
            @(posedge clk);
            #1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        reset    = 1'b1;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        br_taken = 1'b1;
        op       = 6'h00;
        funct    = 6'h00;
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (obs !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_async got=%b exp=%b", obs, outs_t'('0));
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        tests_run++;
        if (obs !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_held got=%b exp=%b", obs, outs_t'('0));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (obs !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle got=%b exp=%b", obs, outs_t'('0));
        end
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic test_alu();
        logic [31:0] words [7] = '{32'h016c5020, 32'h016c5021, 32'h016c5024, 32'h2108ffff,
                                   32'h25080001, 32'h3508abcd, 32'h3c081234};
        bit tr;
        for (int n = 0; n < 7; n++) begin
            exec_instr(words[n], (n == 0) ? 0 : int'($urandom_range(0, 3)), 0, 1'b0, tr);
            foreach (exp_q[i]) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i].v) begin
                    tests_failed++;
                    $display("[TB] FAIL alu w=%h cyc%0d got=%b exp=%b", words[n], i, obs_q[i], exp_q[i].v);
                end
            end
        end
    endtask

    task automatic test_load_store();
        logic [31:0] words [4] = '{32'h8d0b0003, 32'had0a0008, 32'h8d0b0003, 32'had0a0008};
        bit tr;
        for (int n = 0; n < 4; n++) begin
            exec_instr(words[n], 0, (n < 2) ? 3 : int'($urandom_range(0, 5)), 1'b0, tr);
            foreach (exp_q[i]) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i].v) begin
                    tests_failed++;
                    $display("[TB] FAIL ldst w=%h cyc%0d got=%b exp=%b", words[n], i, obs_q[i], exp_q[i].v);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] words [4] = '{32'h1d20fff9, 32'h1d20fff9, 32'h03e00008, 32'h0000000c};
        bit tr;
        for (int n = 0; n < 4; n++) begin
            exec_instr(words[n], 0, 0, (n == 0), tr);
            foreach (exp_q[i]) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i].v) begin
                    tests_failed++;
                    $display("[TB] FAIL branch w=%h cyc%0d got=%b exp=%b", words[n], i, obs_q[i], exp_q[i].v);
                end
            end
        end
    endtask

    task automatic test_jumps_and_illegal();
        logic [31:0] words [5] = '{32'h0c100010, 32'h08100004, 32'h46241000, 32'h0000000d, 32'h016c5022};
        bit tr;
        for (int n = 0; n < 5; n++) begin
            exec_instr(words[n], 1, 0, 1'b0, tr);
            foreach (exp_q[i]) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i].v) begin
                    tests_failed++;
                    $display("[TB] FAIL jump_illegal w=%h cyc%0d got=%b exp=%b", words[n], i, obs_q[i], exp_q[i].v);
                end
            end
            if (tr) do_reset();
        end
    endtask

    task automatic test_timeouts();
        logic [31:0] words [5] = '{32'h016c5020, 32'h8d0b0003, 32'h016c5020, 32'h8d0b0003, 32'had0a0008};
        int          idl   [5] = '{TO - 1, TO - 1, TO, 0, 0};
        int          ddl   [5] = '{0, TO - 1, 0, TO, TO};
        bit tr;
        for (int n = 0; n < 5; n++) begin
            exec_instr(words[n], idl[n], ddl[n], 1'b0, tr);
            foreach (exp_q[i]) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i].v) begin
                    tests_failed++;
                    $display("[TB] FAIL timeout case%0d cyc%0d got=%b exp=%b", n, i, obs_q[i], exp_q[i].v);
                end
            end
            if (tr) do_reset();
        end
    endtask

    task automatic test_reset_mid_mem();
        bit tr;
        imem_ack = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        op       = 6'h23;
        funct    = 6'h03;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        tests_run++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midmem_req got=%b%b exp=10", dmem_req, dmem_we);
        end
        #2;
        dmem_ack = 1'b1;
        imem_ack = 1'b1;
        reset    = 1'b0;
        #1;
        tests_run++;
        if (obs !== '0) begin
            tests_failed++;
            $display("[TB] FAIL midmem_async got=%b exp=%b", obs, outs_t'('0));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (obs !== '0) begin
            tests_failed++;
            $display("[TB] FAIL midmem_idle got=%b exp=%b", obs, outs_t'('0));
        end
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        exec_instr(32'h016c5020, 0, 0, 1'b0, tr);
        foreach (exp_q[i]) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i].v) begin
                tests_failed++;
                $display("[TB] FAIL midmem_resume cyc%0d got=%b exp=%b", i, obs_q[i], exp_q[i].v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pool [18] = '{32'h016c5020, 32'h016c5021, 32'h016c5024, 32'h03e00008,
                                   32'h0000000c, 32'h0000000d, 32'h2108ffff, 32'h25080001,
                                   32'h3508abcd, 32'h3c081234, 32'h8d0b0003, 32'had0a0008,
                                   32'h1d20fff9, 32'h08100010, 32'h0c100010, 32'h46241000,
                                   32'h016c5022, 32'h10000001};
        logic [31:0] w;
        int          k;
        int          idly;
        int          ddly;
        bit          br;
        bit          tr;
        for (int n = 0; n < 60; n++) begin
            k    = int'($urandom_range(0, 17));
            w    = ($urandom_range(0, 4) == 0) ? $urandom() : pool[k];
            idly = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            ddly = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            br   = $urandom_range(0, 1) == 1;
            exec_instr(w, idly, ddly, br, tr);
            foreach (exp_q[i]) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i].v) begin
                    tests_failed++;
                    $display("[TB] FAIL random w=%h cyc%0d got=%b exp=%b", w, i, obs_q[i], exp_q[i].v);
                end
            end
            if (tr) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_jumps_and_illegal();
        test_timeouts();
        test_reset_mid_mem();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
